// File: rtl/br_redirect.sv
// ============================================================================
// Module      : br_redirect
// Description : EX-stage branch/JAL/JALR resolution with registered PC redirect
//               and multi-cycle IF/ID flush. Optional macro: BR_STATS_EN
//               (resolve / taken counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_redirect #(
    parameter int FLUSH_DEPTH = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic            br_unsign,
    input  logic            br_less,
    input  logic            br_equal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            illegal_br,
    output logic            misalign,
    output logic [31:0]     br_count,
    output logic [31:0]     br_taken_count
);

    localparam logic [2:0] c_flush_load = 3'(FLUSH_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              r_redirect_valid, w_redirect_valid_nxt;
    logic [XLEN-1:0]   r_redirect_pc, w_redirect_pc_nxt;
    logic              r_flush, w_flush_nxt;
    logic              r_illegal_br, w_illegal_br_nxt;
    logic              r_misalign, w_misalign_nxt;

    logic              w_resolve;
    logic              w_cond;
    logic              w_branch_only;
    logic              w_illegal_code;
    logic              w_taken;
    logic              w_target_misaligned;
    logic              w_redirect;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_target;

    assign br_unsign = ex_funct3[2] & ex_funct3[1];

    assign w_resolve = (r_state == S_IDLE) & ex_valid & ~ex_stall
                     & (ex_is_branch | ex_is_jal | ex_is_jalr);

    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3)
            3'b000:         w_cond = br_equal;
            3'b001:         w_cond = ~br_equal;
            3'b100, 3'b110: w_cond = br_less;
            3'b101, 3'b111: w_cond = ~br_less;
            default:        w_cond = 1'b0;
        endcase
    end

    // Jumps outrank branches, so condition/illegal decode only matters for a pure branch
    assign w_branch_only  = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    assign w_illegal_code = (ex_funct3[2:1] == 2'b01);
    assign w_taken        = ex_is_jalr | ex_is_jal | (w_branch_only & w_cond);

    assign w_jalr_sum = rs1_data + ex_imm;
    assign w_target   = ex_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);

    assign w_target_misaligned = w_taken & (w_target[1:0] != 2'b00);
    assign w_redirect          = w_resolve & w_taken & ~w_target_misaligned;

    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_flush_nxt          = r_flush;
        w_illegal_br_nxt     = 1'b0;
        w_misalign_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_flush_nxt = 1'b0;
                if (w_resolve) begin
                    w_illegal_br_nxt = w_branch_only & w_illegal_code;
                    w_misalign_nxt   = w_target_misaligned;
                    if (w_redirect) begin
                        w_redirect_valid_nxt = 1'b1;
                        w_redirect_pc_nxt    = w_target;
                        w_flush_nxt          = 1'b1;
                        w_cnt_nxt            = c_flush_load;
                        w_state_nxt          = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Wrong-path instructions in EX are ignored until the counter drains
                if (r_cnt == 3'd0) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_flush_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_illegal_br     <= 1'b0;
            r_misalign       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_flush          <= w_flush_nxt;
            r_illegal_br     <= w_illegal_br_nxt;
            r_misalign       <= w_misalign_nxt;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign illegal_br     = r_illegal_br;
    assign misalign       = r_misalign;

`ifdef BR_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_br_taken_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count       <= 32'd0;
            r_br_taken_count <= 32'd0;
        end else begin
            if (w_resolve) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_redirect) begin
                r_br_taken_count <= r_br_taken_count + 32'd1;
            end
        end
    end

    assign br_count       = r_br_count;
    assign br_taken_count = r_br_taken_count;
`else
    assign br_count       = 32'd0;
    assign br_taken_count = 32'd0;
`endif

endmodule

`default_nettype wire
